kbd_event_ctrl: RTL and testbench

KBD_EVENT_CTRL -- requirements
Module: kbd_event_ctrl

---
 rtl/kbd_event_ctrl.sv | 176 +++++++++++++++++
 tb/tb_kbd_event_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kbd_event_ctrl.sv
// kbd_event_ctrl: turns PS/2 scancode bytes into key events, handling the
// E0/F0 prefixes, shift tracking and an external 1-cycle scancode-to-ASCII table.
//
// Ports:
//   clk, rst             clock and asynchronous active-high reset
//   sc_valid/sc_ready    scancode byte handshake, sc_data carries the byte
//   lut_code/lut_ascii   registered table index out, table result in
//   ev_valid/ev_ready    event handshake; ev_ascii, ev_scan, ev_break, ev_ext
//   shift                current shift-held state
//   press_cnt            number of emitted press events (wraps)
module kbd_event_ctrl #(
    parameter bit EMIT_BREAK = 1'b1,
    parameter bit UPCASE     = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sc_valid,
    input  logic [7:0] sc_data,
    output logic       sc_ready,
    output logic [7:0] lut_code,
    input  logic [7:0] lut_ascii,
    output logic       ev_valid,
    input  logic       ev_ready,
    output logic [7:0] ev_ascii,
    output logic [7:0] ev_scan,
    output logic       ev_break,
    output logic       ev_ext,
    output logic       shift,
    output logic [7:0] press_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOOKUP,
        S_CAPTURE,
        S_OUTPUT
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic       r_ext;
    logic       r_brk;
    logic       r_shift;
    logic [7:0] r_lut_code;
    logic [7:0] r_ascii;
    logic [7:0] r_scan;
    logic       r_ev_break;
    logic       r_ev_ext;
    logic [7:0] r_press_cnt;

    logic       w_sc_fire;
    logic       w_ev_fire;
    logic       w_is_e0;
    logic       w_is_f0;
    logic       w_is_shift_key;
    logic       w_drop;
    logic [7:0] w_ascii;

    assign sc_ready  = (r_state == S_IDLE);
    assign ev_valid  = (r_state == S_OUTPUT);
    assign lut_code  = r_lut_code;
    assign ev_ascii  = r_ascii;
    assign ev_scan   = r_scan;
    assign ev_break  = r_ev_break;
    assign ev_ext    = r_ev_ext;
    assign shift     = r_shift;
    assign press_cnt = r_press_cnt;

    assign w_sc_fire = sc_valid & sc_ready;
    assign w_ev_fire = ev_valid & ev_ready;
    assign w_is_e0   = (sc_data == 8'hE0);
    assign w_is_f0   = (sc_data == 8'hF0);

    // Shift keys are only the plain (non-E0) left/right shift codes.
    assign w_is_shift_key = !r_ext && ((r_scan == 8'h12) || (r_scan == 8'h59));

    // Break events are swallowed here when they are not to be reported.
    assign w_drop = r_brk && !EMIT_BREAK;

    // Uses the shift state from before this key's own update.
    always_comb begin
        w_ascii = lut_ascii;
        if (r_ext) begin
            w_ascii = 8'h00;
        end else if (UPCASE && r_shift &&
                     (lut_ascii >= 8'h61) && (lut_ascii <= 8'h7A)) begin
            w_ascii = lut_ascii - 8'h20;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_sc_fire && !w_is_e0 && !w_is_f0) begin
                    w_next = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                w_next = S_CAPTURE;
            end
            S_CAPTURE: begin
                w_next = w_drop ? S_IDLE : S_OUTPUT;
            end
            S_OUTPUT: begin
                if (w_ev_fire) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ext       <= 1'b0;
            r_brk       <= 1'b0;
            r_shift     <= 1'b0;
            r_lut_code  <= 8'h00;
            r_ascii     <= 8'h00;
            r_scan      <= 8'h00;
            r_ev_break  <= 1'b0;
            r_ev_ext    <= 1'b0;
            r_press_cnt <= 8'h00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_sc_fire) begin
                        if (w_is_e0) begin
                            r_ext <= 1'b1;
                        end else if (w_is_f0) begin
                            r_brk <= 1'b1;
                        end else begin
                            r_lut_code <= sc_data;
                            r_scan     <= sc_data;
                        end
                    end
                end
                S_CAPTURE: begin
                    r_ascii    <= w_ascii;
                    r_ev_break <= r_brk;
                    r_ev_ext   <= r_ext;
                    if (w_is_shift_key) begin
                        r_shift <= !r_brk;
                    end
                    if (w_drop) begin
                        r_ext <= 1'b0;
                        r_brk <= 1'b0;
                    end
                end
                S_OUTPUT: begin
                    if (w_ev_fire) begin
                        r_ext <= 1'b0;
                        r_brk <= 1'b0;
                        if (!r_ev_break) begin
                            r_press_cnt <= r_press_cnt + 8'h01;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_kbd_event_ctrl.sv
// tb_kbd_event_ctrl: scoreboard bench for kbd_event_ctrl; a second instance
// with break events suppressed covers the silent-break path.
module tb_kbd_event_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       sc_valid;
    logic [7:0] sc_data;
    logic       sc_ready;
    logic [7:0] lut_code;
    logic [7:0] lut_ascii;
    logic       ev_valid;
    logic       ev_ready;
    logic [7:0] ev_ascii;
    logic [7:0] ev_scan;
    logic       ev_break;
    logic       ev_ext;
    logic       shift;
    logic [7:0] press_cnt;

    logic       sc2_valid;
    logic [7:0] sc2_data;
    logic       sc2_ready;
    logic [7:0] lut2_code;
    logic [7:0] lut2_ascii;
    logic       ev2_valid;
    logic       ev2_ready;
    logic [7:0] ev2_ascii;
    logic [7:0] ev2_scan;
    logic       ev2_break;
    logic       ev2_ext;
    logic       shift2;
    logic [7:0] press2_cnt;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] s;
        logic       b;
        logic       e;
    } exp_t;

    exp_t       q[$];
    int         errors = 0;
    int         checks = 0;
    logic [7:0] m_press = 8'h00;

    always #5 clk = ~clk;

    kbd_event_ctrl dut (
        .clk(clk), .rst(rst),
        .sc_valid(sc_valid), .sc_data(sc_data), .sc_ready(sc_ready),
        .lut_code(lut_code), .lut_ascii(lut_ascii),
        .ev_valid(ev_valid), .ev_ready(ev_ready),
        .ev_ascii(ev_ascii), .ev_scan(ev_scan),
        .ev_break(ev_break), .ev_ext(ev_ext),
        .shift(shift), .press_cnt(press_cnt)
    );

    kbd_event_ctrl #(.EMIT_BREAK(1'b0), .UPCASE(1'b1)) dut_nb (
        .clk(clk), .rst(rst),
        .sc_valid(sc2_valid), .sc_data(sc2_data), .sc_ready(sc2_ready),
        .lut_code(lut2_code), .lut_ascii(lut2_ascii),
        .ev_valid(ev2_valid), .ev_ready(ev2_ready),
        .ev_ascii(ev2_ascii), .ev_scan(ev2_scan),
        .ev_break(ev2_break), .ev_ext(ev2_ext),
        .shift(shift2), .press_cnt(press2_cnt)
    );

    function automatic logic [7:0] tbl(input logic [7:0] c);
        case (c)
            8'h15:   tbl = 8'h71;
            8'h1C:   tbl = 8'h61;
            8'h12:   tbl = 8'h00;
            8'h59:   tbl = 8'h00;
            8'h75:   tbl = 8'h38;
            default: tbl = 8'h3F;
        endcase
    endfunction

    // Table model with a registered read.
    always @(posedge clk) begin
        lut_ascii  <= tbl(lut_code);
        lut2_ascii <= tbl(lut2_code);
    end

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    task automatic expect_ev(input logic [7:0] a, input logic [7:0] s,
                             input logic b, input logic e);
        exp_t x;
        x.a = a;
        x.s = s;
        x.b = b;
        x.e = e;
        q.push_back(x);
        if (!b) m_press = m_press + 8'h01;
    endtask

    // Monitor: compares each event as it is handed over.
    always @(negedge clk) begin
        if (!rst && ev_valid && ev_ready) begin
            exp_t x;
            exp_t g;
            g.a = ev_ascii;
            g.s = ev_scan;
            g.b = ev_break;
            g.e = ev_ext;
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event: got %h want none", g);
            end else begin
                x = q.pop_front();
                if (g !== x) begin
                    errors++;
                    $display("FAIL event: got %h want %h", g, x);
                end
            end
        end
        if (!rst && ev2_valid && ev2_break) begin
            checks++;
            errors++;
            $display("FAIL nb_break_emitted: got 1 want 0");
        end
    end

    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        sc_valid = 1'b1;
        sc_data  = b;
        while (!sc_ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!sc_ready) chk("send_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        sc_valid = 1'b0;
    endtask

    task automatic send2(input logic [7:0] b);
        int n;
        n = 0;
        sc2_valid = 1'b1;
        sc2_data  = b;
        while (!sc2_ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!sc2_ready) chk("send2_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        sc2_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(sc_ready && !ev_valid && q.size() == 0) && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 400) chk("idle_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        logic [25:0] snap;
        int          n;
        rst       = 1'b1;
        sc_valid  = 1'b0;
        sc_data   = 8'h00;
        ev_ready  = 1'b1;
        sc2_valid = 1'b0;
        sc2_data  = 8'h00;
        ev2_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs",
            {ev_valid, ev_break, ev_ext, shift, lut_code, ev_ascii, ev_scan, press_cnt},
            32'h0);
        rst = 1'b0;
        chk("reset_sc_ready", sc_ready, 1'b1);

        // Plain press with latency check.
        expect_ev(8'h71, 8'h15, 1'b0, 1'b0);
        send(8'h15);
        @(posedge clk);
        #1;
        chk("latency_k1", ev_valid, 1'b0);
        @(posedge clk);
        #1;
        chk("latency_k2", ev_valid, 1'b1);
        wait_idle();
        chk("press_cnt_1", press_cnt, m_press);

        // Shift then letter, then shift release.
        expect_ev(8'h00, 8'h12, 1'b0, 1'b0);
        send(8'h12);
        wait_idle();
        chk("shift_set", shift, 1'b1);
        expect_ev(8'h51, 8'h15, 1'b0, 1'b0);
        send(8'h15);
        expect_ev(8'h00, 8'h12, 1'b1, 1'b0);
        send(8'hF0);
        send(8'h12);
        wait_idle();
        chk("shift_clr", shift, 1'b0);

        // Break and extended keys.
        expect_ev(8'h71, 8'h15, 1'b1, 1'b0);
        send(8'hF0);
        send(8'h15);
        wait_idle();
        chk("press_cnt_brk", press_cnt, m_press);
        expect_ev(8'h00, 8'h75, 1'b0, 1'b1);
        send(8'hE0);
        send(8'h75);
        expect_ev(8'h00, 8'h75, 1'b1, 1'b1);
        send(8'hE0);
        send(8'hF0);
        send(8'h75);
        expect_ev(8'h00, 8'h12, 1'b0, 1'b1);
        send(8'hE0);
        send(8'h12);
        wait_idle();
        chk("ext_no_shift", shift, 1'b0);
        chk("press_cnt_ext", press_cnt, m_press);

        // Consumer stall holds the event.
        ev_ready = 1'b0;
        expect_ev(8'h61, 8'h1C, 1'b0, 1'b0);
        send(8'h1C);
        n = 0;
        while (!ev_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("stall_valid", ev_valid, 1'b1);
        snap = {ev_ascii, ev_scan, ev_break, ev_ext, lut_code};
        repeat (5) begin
            @(posedge clk);
            #1;
            chk("stall_hold",
                {ev_valid, sc_ready, ev_ascii, ev_scan, ev_break, ev_ext, lut_code},
                {1'b1, 1'b0, snap});
        end
        ev_ready = 1'b1;
        wait_idle();
        chk("press_cnt_stall", press_cnt, m_press);

        // Fill up to 256 presses to exercise the wrap.
        n = 256 - int'(m_press);
        for (int i = 0; i < n; i++) begin
            expect_ev(8'h61, 8'h1C, 1'b0, 1'b0);
            send(8'h1C);
        end
        wait_idle();
        chk("press_cnt_wrap", press_cnt, 8'h00);

        // Reset during LOOKUP abandons the event.
        expect_ev(8'h71, 8'h15, 1'b0, 1'b0);
        send(8'h15);
        wait_idle();
        chk("press_cnt_pre_rst", press_cnt, 8'h01);
        send(8'h15);
        rst = 1'b1;
        #1;
        chk("rst_async",
            {sc_ready, ev_valid, ev_break, ev_ext, shift,
             lut_code, ev_ascii, ev_scan, press_cnt},
            {1'b1, 36'h0});
        m_press = 8'h00;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
            chk("rst_no_event", {ev_valid, press_cnt}, 9'h0);
        end

        // Silent breaks on the second instance.
        send2(8'hF0);
        send2(8'h15);
        @(posedge clk);
        #1;
        chk("nb_capture", {ev2_valid, sc2_ready}, 2'b00);
        @(posedge clk);
        #1;
        chk("nb_back_idle", {ev2_valid, sc2_ready}, 2'b01);
        send2(8'h15);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("nb_press_ev",
            {ev2_valid, ev2_ascii, ev2_scan, ev2_break, ev2_ext},
            {1'b1, 8'h71, 8'h15, 1'b0, 1'b0});
        @(posedge clk);
        #1;
        chk("nb_press_cnt", press2_cnt, 8'h01);

        chk("queue_empty", q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
